hp_manager: RTL

HP_MANAGER -- requirements
Module: hp_manager

---
 rtl/hp_manager.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hp_manager.sv
// rtl/hp_manager.sv - two-player HP tracker with animated drain, invulnerability window and KO hold
// Hits queue damage into a saturating pending register that drains 1 HP per frame tick.
module hp_manager #(
    parameter int TOTAL_HP      = 20,
    parameter int INVULN_FRAMES = 30,
    parameter int KO_FRAMES     = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        hit1,
    input  logic        hit2,
    input  logic [4:0]  dmg1,
    input  logic [4:0]  dmg2,
    output logic [18:0] hp1,
    output logic [18:0] hp2,
    output logic        exist_hp,
    output logic        hit_ack1,
    output logic        hit_ack2,
    output logic [1:0]  winner,
    output logic        round_done
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int KO_W  = $clog2(KO_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, FIGHT, KO} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic [18:0]        hp1_q, hp1_d, hp2_q, hp2_d;
    logic [4:0]         pend1_q, pend1_d, pend2_q, pend2_d;
    logic [INV_W-1:0]   inv1_q, inv1_d, inv2_q, inv2_d;
    logic [KO_W-1:0]    ko_cnt_q, ko_cnt_d;
    logic [1:0]         winner_q, winner_d;
    logic               ack1_q, ack1_d, ack2_q, ack2_d;
    logic               round_done_q, round_done_d;

    logic tick, fight, acc1, acc2, drain1, drain2;

    // pending - drain + dmg never goes negative because drain requires pending > 0
    function automatic logic [4:0] sat_pend(input logic [4:0] pend, input logic drain,
                                            input logic [4:0] add);
        logic [5:0] sum;
        sum = {1'b0, pend} - {5'b0, drain} + {1'b0, add};
        return sum[5] ? 5'd31 : sum[4:0];
    endfunction

    assign tick   = sync2_q & ~sync3_q;
    assign fight  = (state_q == FIGHT);
    assign acc1   = fight & hit1 & (inv1_q == '0) & (hp1_q != '0) & (dmg1 != '0);
    assign acc2   = fight & hit2 & (inv2_q == '0) & (hp2_q != '0) & (dmg2 != '0);
    assign drain1 = fight & tick & (pend1_q != '0) & (hp1_q != '0);
    assign drain2 = fight & tick & (pend2_q != '0) & (hp2_q != '0);

    always_comb begin
        state_d      = state_q;
        hp1_d        = hp1_q;
        hp2_d        = hp2_q;
        pend1_d      = pend1_q;
        pend2_d      = pend2_q;
        inv1_d       = inv1_q;
        inv2_d       = inv2_q;
        ko_cnt_d     = ko_cnt_q;
        winner_d     = winner_q;
        ack1_d       = acc1;
        ack2_d       = acc2;
        round_done_d = 1'b0;

        if (fight) begin
            hp1_d   = hp1_q - {18'b0, drain1};
            hp2_d   = hp2_q - {18'b0, drain2};
            pend1_d = sat_pend(pend1_q, drain1, acc1 ? dmg1 : 5'd0);
            pend2_d = sat_pend(pend2_q, drain2, acc2 ? dmg2 : 5'd0);
            if (hp1_d == '0) pend1_d = '0;
            if (hp2_d == '0) pend2_d = '0;

            if (acc1)                          inv1_d = INV_W'(INVULN_FRAMES);
            else if (tick && inv1_q != '0)     inv1_d = inv1_q - 1'b1;
            if (acc2)                          inv2_d = INV_W'(INVULN_FRAMES);
            else if (tick && inv2_q != '0)     inv2_d = inv2_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FIGHT;
                    hp1_d    = 19'(TOTAL_HP);
                    hp2_d    = 19'(TOTAL_HP);
                    pend1_d  = '0;
                    pend2_d  = '0;
                    inv1_d   = '0;
                    inv2_d   = '0;
                    ko_cnt_d = '0;
                    winner_d = 2'b00;
                end
            end
            FIGHT: begin
                // Bit 1 flags player 1 down, bit 0 player 2 down; both gives a draw
                if (hp1_q == '0 || hp2_q == '0) begin
                    state_d  = KO;
                    winner_d = {hp1_q == '0, hp2_q == '0};
                    ko_cnt_d = '0;
                end
            end
            KO: begin
                if (tick) begin
                    if (ko_cnt_q == KO_W'(KO_FRAMES - 1)) begin
                        state_d      = IDLE;
                        round_done_d = 1'b1;
                        ko_cnt_d     = '0;
                    end else begin
                        ko_cnt_d = ko_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            hp1_q        <= 19'(TOTAL_HP);
            hp2_q        <= 19'(TOTAL_HP);
            pend1_q      <= '0;
            pend2_q      <= '0;
            inv1_q       <= '0;
            inv2_q       <= '0;
            ko_cnt_q     <= '0;
            winner_q     <= 2'b00;
            ack1_q       <= 1'b0;
            ack2_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= frame_clk;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            hp1_q        <= hp1_d;
            hp2_q        <= hp2_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            inv1_q       <= inv1_d;
            inv2_q       <= inv2_d;
            ko_cnt_q     <= ko_cnt_d;
            winner_q     <= winner_d;
            ack1_q       <= ack1_d;
            ack2_q       <= ack2_d;
            round_done_q <= round_done_d;
        end
    end

    assign hp1        = hp1_q;
    assign hp2        = hp2_q;
    assign exist_hp   = (state_q != IDLE);
    assign hit_ack1   = ack1_q;
    assign hit_ack2   = ack2_q;
    assign winner     = winner_q;
    assign round_done = round_done_q;

endmodule
